// File: rtl/decoder_sched.sv
// Sequencer for the constant-weight decoder core: codeword FIFO, start pulse, bit packer with valid/ready output.
// msg_valid one cycle after the MSG_W-th dec_ready; a packed word is dropped (err_overrun) if the holding reg is blocked.
module decoder_sched #(
  parameter int CW_W  = 11,
  parameter int DEPTH = 8,
  parameter int MSG_W = 8,
  parameter int NB_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW_W-1:0] cw_in,
  input  logic            cw_in_valid,
  output logic            cw_in_ready,
  input  logic            frame_start,
  output logic            dec_rst_b,
  output logic            dec_start,
  output logic [CW_W-1:0] dec_cw_word,
  output logic            dec_fifoempty,
  input  logic            dec_readfifo,
  input  logic            dec_bin_msg,
  input  logic            dec_ready,
  input  logic            dec_done,
  output logic [MSG_W-1:0] msg_out,
  output logic [NB_W-1:0] msg_nbits,
  output logic            msg_last,
  output logic            msg_valid,
  input  logic            msg_ready,
  output logic            busy,
  output logic            frame_done,
  output logic            err_underflow,
  output logic            err_overrun
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_FLUSH, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic [CW_W-1:0]  r_dec_cw;
  logic             r_err_uf;
  logic             r_err_ov;
  logic             r_dec_rst_b;
  logic [MSG_W-1:0] r_acc;
  logic [NB_W-1:0]  r_bitcnt;
  logic [MSG_W-1:0] r_msg;
  logic [NB_W-1:0]  r_nbits;
  logic             r_last;
  logic             r_msg_vld;

  logic             w_push;
  logic             w_pop;
  logic             w_bit_in;
  logic             w_word_full;
  logic             w_hold_free;
  logic             w_xfer;
  logic [MSG_W-1:0] w_acc_upd;
  logic             w_dec_start;
  logic             w_frame_done;

  assign cw_in_ready   = (r_cnt != (AW+1)'(DEPTH));
  assign dec_fifoempty = (r_cnt == '0);
  assign w_push        = cw_in_valid && cw_in_ready;
  assign w_pop         = dec_readfifo && !dec_fifoempty;

  // Storage has no reset; emptiness is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= cw_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_dec_cw <= '0;
      r_err_uf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd     <= r_rd + AW'(1);
        r_dec_cw <= r_mem[r_rd];
      end
      if (dec_readfifo && dec_fifoempty) r_err_uf <= 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    r_dec_rst_b <= !rst;
  end

  assign w_bit_in    = (r_state == S_RUN) && dec_ready;
  assign w_word_full = w_bit_in && (r_bitcnt == NB_W'(MSG_W - 1));
  assign w_hold_free = !r_msg_vld || msg_ready;
  assign w_xfer      = r_msg_vld && msg_ready;
  assign w_acc_upd   = r_acc | (MSG_W'(dec_bin_msg) << r_bitcnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dec_start  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_START;
      S_START: begin
        w_dec_start = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:   if (dec_done) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_hold_free) w_state_nxt = S_FIN;
      S_FIN: begin
        if (w_xfer) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_bitcnt  <= '0;
      r_msg     <= '0;
      r_nbits   <= '0;
      r_last    <= 1'b0;
      r_msg_vld <= 1'b0;
      r_err_ov  <= 1'b0;
    end else begin
      if (w_xfer) r_msg_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_acc    <= '0;
            r_bitcnt <= '0;
          end
        end
        S_RUN: begin
          if (w_word_full) begin
            r_acc    <= '0;
            r_bitcnt <= '0;
            if (w_hold_free) begin
              r_msg     <= w_acc_upd;
              r_nbits   <= NB_W'(MSG_W);
              r_last    <= 1'b0;
              r_msg_vld <= 1'b1;
            end else begin
              r_err_ov <= 1'b1;
            end
          end else if (w_bit_in) begin
            r_acc    <= w_acc_upd;
            r_bitcnt <= r_bitcnt + NB_W'(1);
          end
        end
        S_FLUSH: begin
          // Partial (possibly empty) tail word; unused acc bits are already zero.
          if (w_hold_free) begin
            r_msg     <= r_acc;
            r_nbits   <= r_bitcnt;
            r_last    <= 1'b1;
            r_msg_vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_rst_b     = r_dec_rst_b;
  assign dec_start     = w_dec_start;
  assign dec_cw_word   = r_dec_cw;
  assign msg_out       = r_msg;
  assign msg_nbits     = r_nbits;
  assign msg_last      = r_last;
  assign msg_valid     = r_msg_vld;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = w_frame_done;
  assign err_underflow = r_err_uf;
  assign err_overrun   = r_err_ov;

endmodule

// File: tb/tb_decoder_sched.sv
// Directed bench for decoder_sched: scoreboard queue of expected message words checked by a monitor.
module tb_decoder_sched;
  localparam int CW_W = 11, DEPTH = 8, MSG_W = 8, NB_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [CW_W-1:0] cw_in;
  logic cw_in_valid, cw_in_ready, frame_start, dec_rst_b, dec_start;
  logic [CW_W-1:0] dec_cw_word;
  logic dec_fifoempty, dec_readfifo, dec_bin_msg, dec_ready, dec_done;
  logic [MSG_W-1:0] msg_out;
  logic [NB_W-1:0] msg_nbits;
  logic msg_last, msg_valid, msg_ready, busy, frame_done, err_underflow, err_overrun;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;

  always #5 clk = ~clk;

  decoder_sched #(.CW_W(CW_W), .DEPTH(DEPTH), .MSG_W(MSG_W), .NB_W(NB_W)) dut (
    .clk(clk), .rst(rst), .cw_in(cw_in), .cw_in_valid(cw_in_valid), .cw_in_ready(cw_in_ready),
    .frame_start(frame_start), .dec_rst_b(dec_rst_b), .dec_start(dec_start), .dec_cw_word(dec_cw_word),
    .dec_fifoempty(dec_fifoempty), .dec_readfifo(dec_readfifo), .dec_bin_msg(dec_bin_msg),
    .dec_ready(dec_ready), .dec_done(dec_done), .msg_out(msg_out), .msg_nbits(msg_nbits),
    .msg_last(msg_last), .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy),
    .frame_done(frame_done), .err_underflow(err_underflow), .err_overrun(err_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Drive n bits (LSB of bits first), then one dec_done cycle.
  task automatic send_bits(input logic [15:0] bits, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      dec_ready   = 1'b1;
      dec_bin_msg = bits[i];
      step();
    end
    dec_ready   = 1'b0;
    dec_bin_msg = 1'b0;
    if (with_done) begin
      dec_done = 1'b1;
      step();
      dec_done = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 50) begin
      step();
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && frame_done) fd_cnt++;
    if (!rst && msg_valid && msg_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL msg_unexpected: got 0x%0h nbits %0d last %0d expected no word", msg_out, msg_nbits, msg_last);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("msg_word", {19'd0, msg_out, msg_nbits, msg_last}, {19'd0, mon_exp});
      end
    end
  end

  initial begin
    rst = 1'b1; cw_in = '0; cw_in_valid = 1'b0; frame_start = 1'b0; dec_readfifo = 1'b0;
    dec_bin_msg = 1'b0; dec_ready = 1'b0; dec_done = 1'b0; msg_ready = 1'b0;

    // 1: reset
    step(); step();
    @(negedge clk);
    chk("rst_dec_rst_b", {31'd0, dec_rst_b}, 0);
    chk("rst_fifoempty", {31'd0, dec_fifoempty}, 1);
    chk("rst_cw_in_ready", {31'd0, cw_in_ready}, 1);
    chk("rst_outs", {busy, msg_valid, msg_last, dec_start, frame_done, err_underflow, err_overrun}, 0);
    chk("rst_data", {dec_cw_word, msg_out, msg_nbits}, 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("dec_rst_b_release", {31'd0, dec_rst_b}, 1);

    // 2: fill FIFO then drain in order
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      cw_in = CW_W'(i);
      cw_in_valid = 1'b1;
    end
    step();
    cw_in_valid = 1'b0;
    @(negedge clk);
    chk("full_cw_in_ready", {31'd0, cw_in_ready}, 0);
    chk("full_not_empty", {31'd0, dec_fifoempty}, 0);
    step();
    dec_readfifo = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) dec_readfifo = 1'b0;
      @(negedge clk);
      chk("fifo_order", {21'd0, dec_cw_word}, i);
    end
    chk("drained_empty", {31'd0, dec_fifoempty}, 1);

    // 3: packing with msg_ready high
    msg_ready = 1'b1;
    exp_q.push_back({8'h4D, 4'd8, 1'b0});
    exp_q.push_back({8'h07, 4'd4, 1'b1});
    step();
    start_frame();
    @(negedge clk);
    chk("dec_start_pulse", {31'd0, dec_start}, 1);
    chk("busy_start", {31'd0, busy}, 1);
    step();
    @(negedge clk);
    chk("dec_start_one_cycle", {31'd0, dec_start}, 0);
    step();
    send_bits(16'h074D, 12, 1'b1);
    wait_idle("t3_idle");
    chk("t3_frame_done", fd_cnt, 1);

    // 4: backpressure, second word dropped
    msg_ready = 1'b0;
    exp_q.push_back({8'hA5, 4'd8, 1'b0});
    exp_q.push_back({8'h00, 4'd0, 1'b1});
    start_frame();
    step();
    send_bits(16'h3CA5, 16, 1'b1);
    step(); step();
    @(negedge clk);
    chk("t4_held_word", {24'd0, msg_out}, 32'hA5);
    chk("t4_held_vld_last", {msg_valid, msg_last}, 2'b10);
    chk("t4_overrun", {31'd0, err_overrun}, 1);
    chk("t4_busy_flush", {31'd0, busy}, 1);
    step();
    msg_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_frame_done", fd_cnt, 2);

    // 5: underflow
    dec_readfifo = 1'b1;
    step();
    dec_readfifo = 1'b0;
    @(negedge clk);
    chk("t5_underflow", {31'd0, err_underflow}, 1);
    chk("t5_cw_hold", {21'd0, dec_cw_word}, 32'h008);
    chk("t5_overrun_sticky", {31'd0, err_overrun}, 1);

    // 6: exact fill, then abort mid-RUN
    step();
    exp_q.push_back({8'h96, 4'd8, 1'b0});
    exp_q.push_back({8'h00, 4'd0, 1'b1});
    start_frame();
    step();
    send_bits(16'h0096, 8, 1'b1);
    wait_idle("t6_idle");
    chk("t6_frame_done", fd_cnt, 3);
    start_frame();
    step();
    send_bits(16'h0005, 3, 1'b0);
    @(negedge clk);
    chk("t6_busy_run", {31'd0, busy}, 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_abort_busy", {31'd0, busy}, 0);
    chk("t6_abort_vld", {31'd0, msg_valid}, 0);
    chk("t6_abort_rst_b", {31'd0, dec_rst_b}, 0);
    chk("t6_err_clear", {err_underflow, err_overrun}, 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_b_back", {31'd0, dec_rst_b}, 1);
    chk("t6_still_idle", {31'd0, busy}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
